// File: rtl/bist_seq_pkg.sv
// Shared state encoding and default parameters for the BIST step sequencer.
// The PAUSE encoding exists in every build; only BIST_STEP_SEQ_PAUSE_EN makes it reachable.
package bist_seq_pkg;

   localparam int BIST_SEQ_NUM_STEPS_DFLT   = 8;
   localparam int BIST_SEQ_ACK_TIMEOUT_DFLT = 255;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      REL,
      DRAIN,
      DONE,
      ERR,
      PAUSE
   } bist_seq_state_e;

endpackage

// File: rtl/bist_ack_timer.sv
// Per-phase handshake timeout: a down-counter reloaded on every state entry.
// expired is the terminal-count flag and holds, because the counter saturates at zero.
module bist_ack_timer #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic bist_clk,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   logic [TO_W-1:0] remain;

   // The reload value is ACK_TIMEOUT-1, so expired is seen in the ACK_TIMEOUT-th waiting cycle.
   always_ff @(posedge bist_clk or negedge reset_n) begin
      if (!reset_n) begin
         remain <= '0;
      end else if (load) begin
         remain <= TO_W'(ACK_TIMEOUT - 1);
      end else if (en && (remain != '0)) begin
         remain <= remain - 1'b1;
      end
   end

   assign expired = (remain == '0);

endmodule

// File: rtl/bist_step_sequencer.sv
// Four-phase req/ack master that steps a BIST engine NUM_STEPS times and reports status.
// Optional pause between steps is enabled by defining BIST_STEP_SEQ_PAUSE_EN.
//
// state | meaning
// IDLE  | waiting for start; aborted run ends here
// REQ   | bist_next high, waiting for ack high
// REL   | bist_next low, waiting for ack low to count the step
// DRAIN | abort seen, waiting for ack low before returning to IDLE
// DONE  | all steps counted
// ERR   | ack phase timed out; left only by start or reset
// PAUSE | between steps, held by pause (optional)
module bist_step_sequencer
   import bist_seq_pkg::*;
#(
   parameter int NUM_STEPS   = BIST_SEQ_NUM_STEPS_DFLT,
   parameter int ACK_TIMEOUT = BIST_SEQ_ACK_TIMEOUT_DFLT,
   localparam int STEP_W     = $clog2(NUM_STEPS + 1)
) (
   input  logic              bist_clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
`ifdef BIST_STEP_SEQ_PAUSE_EN
   input  logic              pause,
`endif
   output logic              bist_next,
   input  logic              bist_next_ack,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              error,
   output logic [STEP_W-1:0] step_idx,
   output logic [STEP_W-1:0] err_step
);

   localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

   bist_seq_state_e state_q, state_d;
   logic            step_inc;
   logic            start_acc;
   logic            expired;

   bist_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
      .bist_clk (bist_clk),
      .reset_n  (reset_n),
      .load     (state_d != state_q),
      .en       (state_q inside {REQ, REL, DRAIN}),
      .expired  (expired)
   );

   assign start_acc = start && (state_q inside {IDLE, DONE, ERR});

   // Abort outranks ack, and ack outranks a same-cycle timeout.
   always_comb begin
      state_d  = state_q;
      step_inc = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) state_d = REQ;
         end
         REQ: begin
            if (abort)              state_d = DRAIN;
            else if (bist_next_ack) state_d = REL;
            else if (expired)       state_d = ERR;
         end
         REL: begin
            if (abort) begin
               state_d = DRAIN;
            end else if (!bist_next_ack) begin
               step_inc = 1'b1;
               if (step_idx == LAST_IDX) state_d = DONE;
`ifdef BIST_STEP_SEQ_PAUSE_EN
               else                      state_d = pause ? PAUSE : REQ;
`else
               else                      state_d = REQ;
`endif
            end else if (expired) begin
               state_d = ERR;
            end
         end
         DRAIN: begin
            if (!bist_next_ack) state_d = IDLE;
            else if (expired)   state_d = ERR;
         end
`ifdef BIST_STEP_SEQ_PAUSE_EN
         PAUSE: begin
            if (abort)       state_d = IDLE;
            else if (!pause) state_d = REQ;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge bist_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bist_next <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         error     <= 1'b0;
         step_idx  <= '0;
         err_step  <= '0;
      end else begin
         state_q   <= state_d;
         bist_next <= (state_d == REQ);
         busy      <= state_d inside {REQ, REL, DRAIN, PAUSE};
         if (start_acc) begin
            step_idx <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            error    <= 1'b0;
         end
         if (step_inc) step_idx <= step_idx + 1'b1;
         if ((state_d == DONE) && (state_q != DONE)) done <= 1'b1;
         if ((state_d == IDLE) && (state_q inside {DRAIN, PAUSE})) aborted <= 1'b1;
         if ((state_d == ERR) && (state_q != ERR)) begin
            error    <= 1'b1;
            err_step <= step_idx;
         end
      end
   end

endmodule

// File: tb/tb_bist_step_sequencer.sv
// Directed bench for bist_step_sequencer with a delay-programmable ack responder and a
// scoreboard of the step index expected at every bist_next rise.
module tb_bist_step_sequencer;

   localparam int NS = 4;
   localparam int TO = 255;
   localparam int SW = $clog2(NS + 1);

   logic bist_clk = 1'b0;
   logic reset_n = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic bist_next_ack = 1'b0;
`ifdef BIST_STEP_SEQ_PAUSE_EN
   logic pause = 1'b0;
`endif
   logic bist_next, busy, done, aborted, error;
   logic [SW-1:0] step_idx, err_step;

   int total = 0;
   int bad = 0;
   int slow_step = -1;
   int slow_dly = 1;
   int fall_dly = 1;
   int eng_w = 0;
   int eng_rises = 0;
   logic prev_next = 1'b0;
   logic [SW-1:0] exp_q[$];
   logic [SW-1:0] exp_val;

   always #5 bist_clk = ~bist_clk;

   bist_step_sequencer #(.NUM_STEPS(NS), .ACK_TIMEOUT(TO)) dut (
      .bist_clk      (bist_clk),
      .reset_n       (reset_n),
      .start         (start),
      .abort         (abort),
`ifdef BIST_STEP_SEQ_PAUSE_EN
      .pause         (pause),
`endif
      .bist_next     (bist_next),
      .bist_next_ack (bist_next_ack),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted),
      .error         (error),
      .step_idx      (step_idx),
      .err_step      (err_step)
   );

   // Engine model: ack follows bist_next once the mismatch has been seen for dly+1 samples,
   // so dly=1 behaves like a registered follower (4-cycle step period).
   initial forever begin
      @(posedge bist_clk);
      #1;
      if (!reset_n) begin
         bist_next_ack = 1'b0;
         eng_w = 0;
      end else if (bist_next != bist_next_ack) begin
         eng_w++;
         if (eng_w > (bist_next ? ((eng_rises == slow_step) ? slow_dly : 1) : fall_dly)) begin
            if (bist_next) eng_rises++;
            bist_next_ack = bist_next;
            eng_w = 0;
         end
      end else begin
         eng_w = 0;
      end
   end

   initial forever begin
      @(negedge bist_clk);
      if (bist_next && !prev_next) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL req_unexpected observed step_idx=%0d expected no request", step_idx);
         end
         if (exp_q.size() != 0) begin
            exp_val = exp_q.pop_front();
            total++;
            assert (step_idx === exp_val) else begin
               bad++;
               $error("FAIL req_step observed=%0d expected=%0d", step_idx, exp_val);
            end
         end
      end
      prev_next = bist_next;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge bist_clk);
   endtask

   task automatic pulse_start(input int first, input int last);
      for (int i = first; i <= last; i++) exp_q.push_back(SW'(i));
      eng_rises = 0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin
         tick(1);
         n++;
      end
      check(tag, busy, 0);
   endtask

   task automatic wait_req(input int s);
      int n = 0;
      while (!(bist_next && step_idx == SW'(s)) && n < 3000) begin
         tick(1);
         n++;
      end
      check("wait_req", bist_next && (step_idx == SW'(s)), 1);
   endtask

   initial begin
      // reset values
      #1 reset_n = 1'b0;
      tick(3);
      check("rst_next", bist_next, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_error", error, 0);
      check("rst_step", step_idx, 0);
      check("rst_err_step", err_step, 0);
      reset_n = 1'b1;
      tick(2);

      // nominal run: done after exactly 16 cycles
      pulse_start(0, NS - 1);
      check("nom_lat_next", bist_next, 1);
      check("nom_lat_busy", busy, 1);
      tick(15);
      check("nom_done_early", done, 0);
      tick(1);
      check("nom_done", done, 1);
      check("nom_step", step_idx, NS);
      check("nom_busy", busy, 0);
      check("nom_next", bist_next, 0);
      check("nom_reqs", exp_q.size(), 0);

      // 254-cycle ack delay is within budget; a start while busy is ignored
      slow_step = 0;
      slow_dly = 254;
      pulse_start(0, NS - 1);
      check("slow_done_clr", done, 0);
      tick(20);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_idle("slow_idle");
      check("slow_done", done, 1);
      check("slow_error", error, 0);
      check("slow_step", step_idx, NS);

      // 255-cycle ack delay on step 2 times out
      slow_step = 2;
      slow_dly = 255;
      pulse_start(0, 2);
      wait_idle("to_idle");
      check("to_error", error, 1);
      check("to_err_step", err_step, 2);
      check("to_next", bist_next, 0);
      check("to_done", done, 0);
      check("to_step", step_idx, 2);
      slow_step = -1;

      // abort in REQ of step 1 before ack
      pulse_start(0, 1);
      check("ab1_err_clr", error, 0);
      wait_req(1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("ab1_next", bist_next, 0);
      check("ab1_busy", busy, 1);
      wait_idle("ab1_idle");
      check("ab1_aborted", aborted, 1);
      check("ab1_step", step_idx, 1);
      check("ab1_done", done, 0);

      // abort together with ack in REQ: drain waits for ack low, step not counted
      pulse_start(0, 0);
      tick(1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("ab2_next", bist_next, 0);
      check("ab2_busy", busy, 1);
      tick(1);
      check("ab2_drain_wait", busy, 1);
      wait_idle("ab2_idle");
      check("ab2_aborted", aborted, 1);
      check("ab2_step", step_idx, 0);
      check("ab2_error", error, 0);

      // drain with ack stuck high times out to ERR
      fall_dly = 400;
      pulse_start(0, 0);
      tick(1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      wait_idle("dto_idle");
      check("dto_error", error, 1);
      check("dto_aborted", aborted, 0);
      check("dto_err_step", err_step, 0);
      fall_dly = 1;
      tick(5);

      // async reset mid-run, then a full run
      pulse_start(0, 1);
      wait_req(1);
      #1 reset_n = 1'b0;
      #1;
      check("rstm_next", bist_next, 0);
      check("rstm_busy", busy, 0);
      check("rstm_step", step_idx, 0);
      check("rstm_error", error, 0);
      bist_next_ack = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      pulse_start(0, NS - 1);
      wait_idle("rstm_run_idle");
      check("rstm_run_done", done, 1);
      check("rstm_run_step", step_idx, NS);

`ifdef BIST_STEP_SEQ_PAUSE_EN
      // pause held for 500 cycles after step 1
      begin
         logic saw_req = 1'b0;
         pause = 1'b1;
         pulse_start(0, NS - 1);
         tick(8);
         for (int i = 0; i < 500; i++) begin
            tick(1);
            if (bist_next) saw_req = 1'b1;
         end
         check("pause_no_req", saw_req, 0);
         check("pause_busy", busy, 1);
         check("pause_error", error, 0);
         check("pause_step", step_idx, 1);
         pause = 1'b0;
         tick(1);
         check("pause_resume", bist_next, 1);
         wait_idle("pause_idle");
         check("pause_done", done, 1);

         pause = 1'b1;
         pulse_start(0, 0);
         tick(8);
         abort = 1'b1;
         tick(1);
         abort = 1'b0;
         pause = 1'b0;
         check("pause_ab_busy", busy, 0);
         check("pause_ab_aborted", aborted, 1);
         check("pause_ab_step", step_idx, 1);
      end
`endif

      tick(5);
      check("final_reqs", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
